// File: rtl/sysid_pkg.sv
// Shared definitions for the sysid build-match checker: FSM state codes,
// word offsets inside the sysid slave and the word-address helper.
package sysid_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RD_ID  = 3'd1;
    localparam logic [2:0] S_RD_GAP = 3'd2;
    localparam logic [2:0] S_RD_TS  = 3'd3;
    localparam logic [2:0] S_FIN    = 3'd4;

    localparam int unsigned SYSID_WORD_ID  = 0;
    localparam int unsigned SYSID_WORD_TS  = 1;
    localparam int unsigned BYTES_PER_WORD = 4;

    // Byte address of a word; wraps modulo 2^32 like the interconnect does.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input int unsigned word);
        return base + 32'(word * BYTES_PER_WORD);
    endfunction

endpackage

// File: rtl/avm_single_read.sv
// One held Avalon-MM read: address/read stay stable while the slave stalls,
// and the read is abandoned once the stall budget is used up.
module avm_single_read #(
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        active,
    input  logic [31:0] target_addr,
    output logic [31:0] avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        accept,
    output logic        expired,
    output logic [31:0] rdata
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] stall_cnt;

    assign avm_read    = active;
    assign avm_address = active ? target_addr : '0;
    assign rdata       = avm_readdata;
    assign accept      = active && !avm_waitrequest;
    // Acceptance beats the terminal count: expiry needs the slave still stalling.
    assign expired     = active && avm_waitrequest && (stall_cnt == TERM);

    // Idle cycles between reads clear the counter, so each read starts fresh.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (!active) begin
            stall_cnt <= '0;
        end else if (avm_waitrequest && (stall_cnt != TERM)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sysid_check_master.sv
// Reads the sysid slave's ID and timestamp words and compares them with the
// values baked in at build time; the sticky result gates datapath bring-up.
module sysid_check_master
    import sysid_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_ID = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS = 32'd1675032080,
    parameter int unsigned TIMEOUT_CYC = 256,
    parameter bit          AUTO_START  = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic        auto_pend;
    logic        launch;
    logic        rd_active;
    logic        rd_accept;
    logic        rd_expired;
    logic [31:0] rd_target;
    logic [31:0] rd_data;

    assign launch    = (state == S_IDLE) && (start || auto_pend);
    assign rd_active = (state == S_RD_ID) || (state == S_RD_TS);
    assign rd_target = (state == S_RD_TS) ? word_addr(BASE_ADDR, SYSID_WORD_TS)
                                          : word_addr(BASE_ADDR, SYSID_WORD_ID);

    avm_single_read #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rd (
        .clock           (clock),
        .reset_n         (reset_n),
        .active          (rd_active),
        .target_addr     (rd_target),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .accept          (rd_accept),
        .expired         (rd_expired),
        .rdata           (rd_data)
    );

    assign avm_byteenable = 4'hF;
    // Decoded from state so an asynchronous reset drops read/busy immediately.
    assign busy = rd_active || (state == S_RD_GAP);
    assign done = (state == S_FIN);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (launch) state_nxt = S_RD_ID;
            S_RD_ID: begin
                if (rd_accept)       state_nxt = S_RD_GAP;
                else if (rd_expired) state_nxt = S_FIN;
            end
            S_RD_GAP: state_nxt = S_RD_TS;
            S_RD_TS:  if (rd_accept || rd_expired) state_nxt = S_FIN;
            S_FIN:    state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Result flags are sticky across checks and cleared only when a new one launches.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            auto_pend <= AUTO_START;
            id_ok     <= 1'b0;
            ts_ok     <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            id_value  <= '0;
            ts_value  <= '0;
        end else begin
            if (launch) begin
                auto_pend <= 1'b0;
                id_ok     <= 1'b0;
                ts_ok     <= 1'b0;
                pass      <= 1'b0;
                timeout   <= 1'b0;
            end
            if ((state == S_RD_ID) && rd_accept) begin
                id_value <= rd_data;
                id_ok    <= (rd_data == EXPECTED_ID);
            end
            // pass is settled here so it is already valid during the done cycle.
            if ((state == S_RD_TS) && rd_accept) begin
                ts_value <= rd_data;
                ts_ok    <= (rd_data == EXPECTED_TS);
                pass     <= id_ok && (rd_data == EXPECTED_TS);
            end
            if (rd_expired) begin
                timeout <= 1'b1;
                pass    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sysid_check_master.sv
// Bench for sysid_check_master: stalling sysid slave, timeline reference model
// computed per launch, and a per-cycle compare of all outputs against it.
module tb_sysid_check_master;

    localparam logic [31:0] BASE    = 32'hFFFF_FFFC;
    localparam logic [31:0] TS_ADDR = 32'h0000_0000;
    localparam logic [31:0] EXP_ID  = 32'h0000_0000;
    localparam logic [31:0] EXP_TS  = 32'd1675032080;
    localparam int          T       = 8;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = '0;
    logic [31:0] avm_address;
    logic        avm_read;
    logic [3:0]  avm_byteenable;
    logic        busy, done, pass, id_ok, ts_ok, timeout;
    logic [31:0] id_value, ts_value;

    sysid_check_master #(
        .BASE_ADDR   (BASE),
        .EXPECTED_ID (EXP_ID),
        .EXPECTED_TS (EXP_TS),
        .TIMEOUT_CYC (T),
        .AUTO_START  (1'b1)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_byteenable  (avm_byteenable),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .id_ok           (id_ok),
        .ts_ok           (ts_ok),
        .timeout         (timeout),
        .id_value        (id_value),
        .ts_value        (ts_value)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_ok  = 0;

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_ok++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_ok++;
        else $display("FAIL %s: got %b expected %b", nm, act, exp);
    endtask

    // Slave: each read stalls for a per-word number of cycles, then answers.
    int          stall1 = 0;
    int          stall2 = 0;
    logic [31:0] id_data = EXP_ID;
    logic [31:0] ts_data = EXP_TS;
    int          scnt = 0;

    always @(negedge clock) begin
        if (avm_read) begin
            avm_waitrequest = (scnt < ((avm_address == BASE) ? stall1 : stall2));
            avm_readdata    = (avm_address == BASE)    ? id_data :
                              (avm_address == TS_ADDR) ? ts_data : 32'hDEAD_BEEF;
            scnt++;
        end else begin
            scnt            = 0;
            avm_waitrequest = 1'($urandom_range(0, 1));
            avm_readdata    = $urandom;
        end
    end

    // Reference model: at launch, compute the whole timeline of the check
    // (read windows, done cycle) and its final results from the stall counts.
    int          cyc = 0;
    int          m_e = -100, m_fin = -100, r1_end = -100, r2_beg = -100, r2_end = -200;
    bit          m_pend = 1'b1;
    logic [31:0] f_id = '0, f_ts = '0;
    bit          f_idok = 0, f_tsok = 0, f_pass = 0, f_to = 0;

    always @(posedge clock) begin
        cyc++;
        if (!reset_n) begin
            m_pend = 1'b1;
            m_e = -100; m_fin = -100; r1_end = -100; r2_beg = -100; r2_end = -200;
            f_id = '0; f_ts = '0; f_idok = 0; f_tsok = 0; f_pass = 0; f_to = 0;
        end else if (cyc >= m_fin + 2 && (start || m_pend)) begin
            m_pend = 1'b0;
            m_e    = cyc;
            if (stall1 < T) begin
                r1_end = cyc + stall1;
                f_id   = id_data;
                f_idok = (id_data == EXP_ID);
                r2_beg = r1_end + 2;
                if (stall2 < T) begin
                    r2_end = r2_beg + stall2;
                    f_ts   = ts_data;
                    f_tsok = (ts_data == EXP_TS);
                    f_to   = 0;
                end else begin
                    r2_end = r2_beg + T - 1;
                    f_tsok = 0;
                    f_to   = 1;
                end
                m_fin = r2_end + 1;
            end else begin
                r1_end = cyc + T - 1;
                m_fin  = r1_end + 1;
                r2_beg = -100; r2_end = -200;
                f_idok = 0; f_tsok = 0; f_to = 1;
            end
            f_pass = f_idok && f_tsok;
        end
    end

    bit in1, in2;
    always @(negedge clock) begin
        if (reset_n && cyc > 0) begin
            in1 = (cyc >= m_e) && (cyc <= r1_end);
            in2 = (cyc >= r2_beg) && (cyc <= r2_end);
            chk1("avm_read", avm_read, in1 || in2);
            if (in1) chk32("addr_id", avm_address, BASE);
            if (in2) chk32("addr_ts", avm_address, TS_ADDR);
            chk32("byteenable", {28'd0, avm_byteenable}, 32'hF);
            chk1("busy", busy, (cyc >= m_e) && (cyc < m_fin));
            chk1("done", done, cyc == m_fin);
            if (cyc >= m_fin) begin
                chk1("id_ok", id_ok, f_idok);
                chk1("ts_ok", ts_ok, f_tsok);
                chk1("pass", pass, f_pass);
                chk1("timeout", timeout, f_to);
                chk32("id_value", id_value, f_id);
                chk32("ts_value", ts_value, f_ts);
            end else if (cyc == m_e) begin
                chk1("flags_clear", id_ok | ts_ok | pass | timeout, 1'b0);
            end
        end
    end

    task automatic wait_done(output int dc);
        dc = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock); #1;
            if (done) begin
                dc = cyc;
                break;
            end
        end
        if (dc < 0) chk1("done_seen", done, 1'b1);
    endtask

    task automatic run_check(input int s1, input int s2, input logic [31:0] idd,
                             input logic [31:0] tsd, output int lat);
        int c0, dc;
        @(negedge clock);
        stall1 = s1; stall2 = s2; id_data = idd; ts_data = tsd;
        start = 1'b1;
        c0 = cyc;
        @(negedge clock);
        start = 1'b0;
        wait_done(dc);
        lat = dc - c0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, c0, dc, s1, s2;
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk1("rst_read", avm_read, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_pass", pass, 1'b0);
        chk32("rst_id_value", id_value, 32'h0);
        chk32("rst_be", {28'd0, avm_byteenable}, 32'hF);
        @(negedge clock); #2;
        reset_n = 1'b1;

        // automatic check after reset release
        wait_done(dc);
        chk1("auto_pass", pass, 1'b1);

        run_check(0, 0, EXP_ID, EXP_TS, lat);
        chk32("lat_zero_wait", lat, 4);
        chk1("zw_pass", pass, 1'b1);
        chk32("zw_ts_value", ts_value, 32'd1675032080);

        run_check(0, 0, EXP_ID, 32'h1234_5678, lat);
        chk1("badts_id_ok", id_ok, 1'b1);
        chk1("badts_ts_ok", ts_ok, 1'b0);
        chk1("badts_pass", pass, 1'b0);
        chk32("badts_value", ts_value, 32'h1234_5678);

        run_check(5, 5, EXP_ID, EXP_TS, lat);
        chk32("lat_stall5", lat, 14);
        chk1("stall5_pass", pass, 1'b1);

        run_check(0, 1000, EXP_ID, EXP_TS, lat);
        chk32("lat_to_ts", lat, 11);
        chk1("to_ts_timeout", timeout, 1'b1);
        chk1("to_ts_id_ok", id_ok, 1'b1);
        chk1("to_ts_pass", pass, 1'b0);

        // stall of T-1: acceptance coincides with terminal count and wins
        run_check(T - 1, T - 1, EXP_ID, EXP_TS, lat);
        chk32("lat_edge", lat, 18);
        chk1("edge_timeout", timeout, 1'b0);
        chk1("edge_pass", pass, 1'b1);

        run_check(T, 0, EXP_ID, EXP_TS, lat);
        chk32("lat_to_id", lat, 9);
        chk1("to_id_id_ok", id_ok, 1'b0);
        chk1("to_id_timeout", timeout, 1'b1);

        // start during RD_TS is dropped
        @(negedge clock);
        stall1 = 0; stall2 = 3; id_data = EXP_ID; ts_data = EXP_TS;
        start = 1'b1; c0 = cyc;
        @(negedge clock); start = 1'b0;
        @(negedge clock);
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        wait_done(dc);
        chk32("lat_busy_start", dc - c0, 7);
        @(negedge clock); #1;
        chk1("no_requeue", busy, 1'b0);

        run_check(0, 0, 32'h0000_0001, EXP_TS, lat);
        chk1("badid_id_ok", id_ok, 1'b0);
        chk32("badid_value", id_value, 32'h0000_0001);

        for (int i = 0; i < 24; i++) begin
            s1 = ($urandom_range(0, 5) == 0) ? 7 + $urandom_range(0, 3) : $urandom_range(0, 3);
            s2 = ($urandom_range(0, 5) == 0) ? 7 + $urandom_range(0, 3) : $urandom_range(0, 3);
            run_check(s1, s2,
                      ($urandom_range(0, 3) == 0) ? $urandom : EXP_ID,
                      ($urandom_range(0, 3) == 0) ? $urandom : EXP_TS, lat);
        end

        // reset during RD_ID: read drops at once, no done, auto-check reruns
        @(negedge clock);
        stall1 = 4; stall2 = 0; id_data = EXP_ID; ts_data = EXP_TS;
        start = 1'b1;
        @(negedge clock); start = 1'b0;
        @(posedge clock); #2;
        reset_n = 1'b0;
        #1;
        chk1("midrst_read", avm_read, 1'b0);
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_done", done, 1'b0);
        stall1 = 0;
        repeat (2) @(posedge clock);
        @(negedge clock); #2;
        reset_n = 1'b1;
        wait_done(dc);
        chk1("rerun_pass", pass, 1'b1);
        repeat (3) @(negedge clock);

        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end

endmodule
